// File: rtl/mem_io_responder.sv
// Board-side responder for the CPU byte bus: 128 KB RAM, UART TX/RX FIFOs and a
// cycle counter with a sticky program-stop flag. Reads return one edge later.
module mem_io_responder #(
    parameter int    ADDR_WIDTH = 17,
    parameter int    TX_DEPTH   = 8,
    parameter int    RX_DEPTH   = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop
);

    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
    localparam logic [TXW:0] TX_HI   = (TXW+1)'(TX_DEPTH - 2);
    localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

    localparam logic [15:0] OFF_PORT = 16'h0000;
    localparam logic [15:0] OFF_CNT0 = 16'h0004;
    localparam logic [15:0] OFF_CNT1 = 16'h0005;
    localparam logic [15:0] OFF_CNT2 = 16'h0006;
    localparam logic [15:0] OFF_CNT3 = 16'h0007;

    logic                  unused_addr;
    logic                  is_io;
    logic [15:0]           io_off;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  wr_en;
    logic                  ram_we;
    logic                  port_rd;
    logic                  cnt0_rd;
    logic                  port_wr;
    logic                  stop_wr;

    logic [7:0]  ram [2**ADDR_WIDTH];
    logic [7:0]  ram_q;
    logic [7:0]  io_q;
    logic        rd_ram_sel;
    logic [7:0]  io_rdata;
    logic [31:0] cycles;
    logic [31:0] snap;

    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TXW-1:0] tx_wr;
    logic [TXW-1:0] tx_rd;
    logic [TXW:0]   tx_count;
    logic [TXW:0]   tx_count_next;
    logic           tx_push_req;
    logic           tx_push_ok;
    logic           tx_pop;
    logic [7:0]     tx_push_data;

    logic [7:0]   rx_mem [RX_DEPTH];
    logic [RXW-1:0] rx_wr;
    logic [RXW-1:0] rx_rd;
    logic [RXW:0]   rx_count;
    logic           rx_push;
    logic           rx_pop;

    assign unused_addr = ^mem_a[31:18];
    assign is_io       = (mem_a[17:16] == 2'b11);
    assign io_off      = mem_a[15:0];
    assign ram_addr    = mem_a[ADDR_WIDTH-1:0];

    // Once the program has stopped the bus becomes read-only.
    assign wr_en   = mem_wr && !program_stop && !rst_in;
    assign ram_we  = wr_en && !is_io;
    assign port_rd = !mem_wr && is_io && (io_off == OFF_PORT);
    assign cnt0_rd = !mem_wr && is_io && (io_off == OFF_CNT0);
    assign port_wr = wr_en && is_io && (io_off == OFF_PORT) && (mem_dout != 8'h00);
    assign stop_wr = wr_en && is_io && (io_off == OFF_CNT0);

    assign tx_valid     = (tx_count != '0);
    assign tx_data      = tx_mem[tx_rd];
    assign tx_pop       = tx_valid && tx_ready;
    assign tx_push_req  = port_wr || stop_wr;
    assign tx_push_data = stop_wr ? 8'h00 : mem_dout;
    assign tx_push_ok   = tx_push_req && ((tx_count < TX_FULL) || tx_pop);

    assign rx_ready = (rx_count < RX_FULL);
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = port_rd && (rx_count != '0);

    assign mem_din = rd_ram_sel ? ram_q : io_q;

    // RAM kept outside the reset domain so it maps onto block memory.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_addr] <= mem_dout;
        if (!mem_wr) ram_q <= ram[ram_addr];
    end

    always_comb begin
        tx_count_next = tx_count;
        if (tx_push_ok && !tx_pop)
            tx_count_next = tx_count + 1'b1;
        else if (!tx_push_ok && tx_pop)
            tx_count_next = tx_count - 1'b1;
    end

    always_comb begin
        io_rdata = 8'h00;
        if (is_io) begin
            case (io_off)
                OFF_PORT: io_rdata = (rx_count != '0) ? rx_mem[rx_rd] : 8'h00;
                OFF_CNT0: io_rdata = cycles[7:0];
                OFF_CNT1: io_rdata = snap[15:8];
                OFF_CNT2: io_rdata = snap[23:16];
                OFF_CNT3: io_rdata = snap[31:24];
                default:  io_rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycles         <= '0;
            snap           <= '0;
            program_stop   <= 1'b0;
            rd_ram_sel     <= 1'b0;
            io_q           <= 8'h00;
            io_buffer_full <= 1'b0;
            tx_wr          <= '0;
            tx_rd          <= '0;
            tx_count       <= '0;
            rx_wr          <= '0;
            rx_rd          <= '0;
            rx_count       <= '0;
        end else begin
            cycles <= cycles + 32'd1;

            if (!mem_wr) begin
                rd_ram_sel <= !is_io;
                io_q       <= io_rdata;
            end
            // CNT0 snapshot lets CNT1..CNT3 return bytes of the same value.
            if (cnt0_rd) snap <= cycles;
            if (stop_wr) program_stop <= 1'b1;

            if (tx_push_ok) begin
                tx_mem[tx_wr] <= tx_push_data;
                tx_wr         <= tx_wr + 1'b1;
            end
            if (tx_pop) tx_rd <= tx_rd + 1'b1;
            tx_count       <= tx_count_next;
            io_buffer_full <= (tx_count_next >= TX_HI);

            if (rx_push) begin
                rx_mem[rx_wr] <= rx_data;
                rx_wr         <= rx_wr + 1'b1;
            end
            if (rx_pop) rx_rd <= rx_rd + 1'b1;
            if (rx_push && !rx_pop)
                rx_count <= rx_count + 1'b1;
            else if (!rx_push && rx_pop)
                rx_count <= rx_count - 1'b1;
        end
    end

endmodule
